// File: rtl/speed_window_controller.sv
// Windowed wheel-pulse speed monitor with a persistence/hysteresis over-speed FSM.
// Optional peak-hold register and port enabled by defining PEAK_HOLD_EN.
module speed_window_controller #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned WINDOW   = 16,
    parameter int unsigned OVER_RUN = 2,
    parameter int unsigned HYST     = 2
) (
    input  logic             clk,
    input  logic             clr_bar,
    input  logic             en,
    input  logic             w,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] speed,
    output logic             speed_vld,
    output logic             warn,
    output logic             z
`ifdef PEAK_HOLD_EN
    ,
    output logic [CNT_W-1:0] peak
`endif
);

    localparam int unsigned WC_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int unsigned RUN_W = $clog2(OVER_RUN + 1);
    localparam int unsigned CMP_W = CNT_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CRUISE = 2'd1,
        WARN   = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             w_q;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] speed_d;
    logic             speed_vld_d, warn_d, z_d;

    logic             pulse_edge_c;
    logic             close_c;
    logic [CMP_W-1:0] pcnt_sum_c;
    logic [CNT_W-1:0] measured_c;
    logic             over_c, under_c;
    logic [RUN_W:0]   run_inc_c;

    // Measurement datapath: edge detect, saturating close value, limit compares.
    always_comb begin
        pulse_edge_c = w & ~w_q;
        close_c      = en && (wcnt_q == WC_LAST);
        pcnt_sum_c   = {1'b0, pcnt_q} + CMP_W'(pulse_edge_c);
        measured_c   = pcnt_sum_c[CNT_W] ? CNT_MAX : pcnt_sum_c[CNT_W-1:0];
        over_c       = {1'b0, measured_c} > {1'b0, limit};
        under_c      = ({1'b0, measured_c} + CMP_W'(HYST)) <= {1'b0, limit};
        run_inc_c    = (RUN_W+1)'(run_q) + (RUN_W+1)'(1);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        wcnt_d      = wcnt_q;
        run_d       = run_q;
        speed_d     = speed;
        speed_vld_d = 1'b0;

        if (!en) begin
            state_d = IDLE;
            pcnt_d  = '0;
            wcnt_d  = '0;
            run_d   = '0;
            speed_d = '0;
        end else begin
            if (close_c) begin
                pcnt_d      = '0;
                wcnt_d      = '0;
                speed_d     = measured_c;
                speed_vld_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + WC_W'(1);
                if (pulse_edge_c && (pcnt_q != CNT_MAX)) begin
                    pcnt_d = pcnt_q + CNT_W'(1);
                end
            end

            case (state_q)
                IDLE: state_d = CRUISE;
                CRUISE: begin
                    if (close_c && over_c) begin
                        run_d   = RUN_W'(1);
                        state_d = (OVER_RUN == 1) ? OVER : WARN;
                    end
                end
                WARN: begin
                    if (close_c) begin
                        if (over_c) begin
                            run_d = RUN_W'(run_inc_c);
                            if (run_inc_c >= (RUN_W+1)'(OVER_RUN)) begin
                                state_d = OVER;
                            end
                        end else begin
                            run_d   = '0;
                            state_d = CRUISE;
                        end
                    end
                end
                OVER: begin
                    if (close_c && under_c) begin
                        run_d   = '0;
                        state_d = CRUISE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        warn_d = (state_d == WARN);
        z_d    = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge clr_bar) begin
        if (!clr_bar) begin
            state_q   <= IDLE;
            w_q       <= 1'b0;
            pcnt_q    <= '0;
            wcnt_q    <= '0;
            run_q     <= '0;
            speed     <= '0;
            speed_vld <= 1'b0;
            warn      <= 1'b0;
            z         <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w;
            pcnt_q    <= pcnt_d;
            wcnt_q    <= wcnt_d;
            run_q     <= run_d;
            speed     <= speed_d;
            speed_vld <= speed_vld_d;
            warn      <= warn_d;
            z         <= z_d;
        end
    end

`ifdef PEAK_HOLD_EN
    // Peak survives en=0; only the asynchronous clear resets it.
    always_ff @(posedge clk or negedge clr_bar) begin
        if (!clr_bar) begin
            peak <= '0;
        end else if (close_c && (measured_c > peak)) begin
            peak <= measured_c;
        end
    end
`endif

endmodule
